alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Single-issue controller that sits between an instruction source and an
//   external registered ALU. It owns an NREGS x WIDTH register file. For each
//   accepted instruction it does one of three things:
//     - ALU op (0000-1000): present rf[rs1]/rf[rs2] to the ALU for one cycle
//       (EXEC), capture the registered result on the next cycle (WB), write it
//       back and update the sticky flags.
//     - LOADI (1111): write the latched immediate into rf[rd] (LOAD).
//     - any other code (1001-1110): raise a one-cycle illegal pulse (ERR).
//   Only one instruction is in flight at a time, so no forwarding is needed.
//
// Handshake:
//   An instruction transfers on a rising edge where in_valid and in_ready are
//   both high. in_ready is high only in IDLE (and never while reset is high).
//   The upstream must hold in_valid and all instruction fields stable until
//   that edge; offers seen while in_ready is low have no effect.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   instruction handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm   instruction fields
//   alu_a, alu_b, alu_sel operands and op code to the ALU (zeros/1111 idle)
//   alu_out, alu_zero, alu_carry, alu_negative, alu_overflow
//                         registered ALU result and flags
//   wb_valid, wb_rd, wb_data  one-cycle writeback report (rd/data 0 otherwise)
//   flags                 sticky {Z,C,N,V} of the last completed ALU op
//   illegal               one-cycle pulse for a rejected op code
//   dbg_addr / dbg_data   combinational register-file read port
//   dbg_state             current controller state (debug visibility)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  // instruction handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs1,
  input  logic [2:0]       in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  // ALU interface
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  // writeback / status
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags,
  output logic             illegal,
  // debug
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [2:0]       dbg_state
);

  localparam logic [3:0] OP_LOADI   = 4'b1111;
  localparam logic [3:0] OP_ALU_MAX = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WB   = 3'd2,
    S_LOAD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_op;
  logic [2:0]       r_rd;
  logic [2:0]       r_rs1;
  logic [2:0]       r_rs2;
  logic [WIDTH-1:0] r_imm;

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [3:0]       r_flags;

  logic             w_accept;
  logic             w_flag_update;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. Decode happens on the live in_op at the accept edge so
  // the first cycle after accept is already the correct working state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_op == OP_LOADI) begin
            w_state_nxt = S_LOAD;
          end else if (in_op <= OP_ALU_MAX) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      S_LOAD:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs. All are decoded from the current state so that every
  // writeback/illegal report lasts exactly one cycle and returns to zero.
  // In WB the ALU has just registered the result of the EXEC-cycle operands,
  // so alu_out and the ALU flags are valid for that cycle only.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_sel       = OP_LOADI;
    wb_valid      = 1'b0;
    wb_rd         = 3'd0;
    wb_data       = '0;
    illegal       = 1'b0;
    w_flag_update = 1'b0;
    case (r_state)
      S_EXEC: begin
        alu_a   = r_rf[r_rs1];
        alu_b   = r_rf[r_rs2];
        alu_sel = r_op;
      end
      S_WB: begin
        wb_valid      = 1'b1;
        wb_rd         = r_rd;
        wb_data       = alu_out;
        w_flag_update = 1'b1;
      end
      S_LOAD: begin
        wb_valid = 1'b1;
        wb_rd    = r_rd;
        wb_data  = r_imm;
      end
      S_ERR: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched instruction fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= 4'd0;
      r_rd  <= 3'd0;
      r_rs1 <= 3'd0;
      r_rs2 <= 3'd0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_rd  <= in_rd;
      r_rs1 <= in_rs1;
      r_rs2 <= in_rs2;
      r_imm <= in_imm;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The write port is driven by the writeback report itself,
  // so whatever is announced on wb_* is exactly what lands in the array.
  // An asynchronous reset in EXEC returns the FSM to IDLE before WB is ever
  // reached, which is what suppresses the aborted write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_valid) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: only a completed ALU op (WB) changes them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'd0;
    end else if (w_flag_update) begin
      r_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
    end
  end

  assign flags     = r_flags;
  assign dbg_data  = r_rf[dbg_addr];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed bench for alu_issue_ctrl. A registered ALU responder answers the
// DUT's operand bus. The driver keeps a transaction-level register-file model
// and pushes one expected event per accepted instruction; a single compare
// process checks every cycle's writeback/illegal/flags outputs against it.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int W  = 8;
  localparam int EW = 17;  // {kind[2], rd[3], data[8], flags[4]}

  localparam logic [1:0] K_ALU = 2'd1;
  localparam logic [1:0] K_LD  = 2'd2;
  localparam logic [1:0] K_ILL = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_BAD = 4'b1010;
  localparam logic [3:0] OP_LDI = 4'b1111;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'd0;
  logic [2:0]   in_rd = 3'd0;
  logic [2:0]   in_rs1 = 3'd0;
  logic [2:0]   in_rs2 = 3'd0;
  logic [W-1:0] in_imm = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_out = '0;
  logic         alu_zero = 1'b0;
  logic         alu_carry = 1'b0;
  logic         alu_negative = 1'b0;
  logic         alu_overflow = 1'b0;
  logic         wb_valid;
  logic [2:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic [3:0]   flags;
  logic         illegal;
  logic [2:0]   dbg_addr = 3'd0;
  logic [W-1:0] dbg_data;
  logic [2:0]   dbg_state;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  m_rf [8];
  logic [3:0]    cur_flags = 4'd0;
  int            checks = 0;
  int            errors = 0;
  int            wb_cnt = 0;
  int            ill_cnt = 0;
  time           last_acc = 0;

  alu_issue_ctrl #(.WIDTH(W), .NREGS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flags        (flags),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // ALU behaviour: returns {Z, C, N, V, result}. C on SUB is the borrow.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] alu_calc(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = 9'd0;
    r = 8'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[2:0];
      4'd6: r = a >> b[2:0];
      4'd7: r = 8'($signed(a) >>> b[2:0]);
      4'd8: r = {7'd0, ($signed(a) < $signed(b))};
      default: r = 8'd0;
    endcase
    return {(r == 8'd0), c, r[7], v, r};
  endfunction

  // Registered ALU responder: result appears the cycle after operands.
  always @(posedge clk) begin
    {alu_zero, alu_carry, alu_negative, alu_overflow, alu_out} <= alu_calc(alu_sel, alu_a, alu_b);
  end

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle outside reset.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      cur_flags = 4'd0;
    end else begin
      chk("flags", {28'd0, flags}, {28'd0, cur_flags});
      if (wb_valid || illegal) begin
        if (wb_valid) wb_cnt++;
        if (illegal) ill_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, wb_valid, illegal}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, wb_valid, illegal},
              (e[16:15] == K_ILL) ? 32'd1 : 32'd2);
          if (e[16:15] != K_ILL) begin
            chk("wb_rd", {29'd0, wb_rd}, {29'd0, e[14:12]});
            chk("wb_data", {24'd0, wb_data}, {24'd0, e[11:4]});
          end
          if (e[16:15] == K_ALU) cur_flags = e[3:0];
        end
      end else begin
        chk("wb_idle_zero", {21'd0, wb_rd, wb_data}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
  endtask

  // Offers an instruction and returns just after its accept edge; in_valid
  // stays high so a following issue() can queue behind it.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm);
    int n;
    logic [11:0] r;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (op == OP_LDI) begin
      m_rf[rd] = imm;
      exp_q.push_back({K_LD, rd, imm, 4'd0});
    end else if (op <= 4'd8) begin
      r = alu_calc(op, m_rf[rs1], m_rf[rs2]);
      m_rf[rd] = r[7:0];
      exp_q.push_back({K_ALU, rd, r[7:0], r[11:8]});
    end else begin
      exp_q.push_back({K_ILL, 3'd0, 8'd0, 4'd0});
    end
    @(posedge clk);
    last_acc = $time;
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [7:0] exp, input string name);
    dbg_addr = idx;
    #1;
    chk(name, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 8; i++) check_reg(3'(i), m_rf[i], "rf_model");
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    time t1;
    int  wb_before;
    int  ill_before;

    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_outputs", {29'd0, wb_valid, illegal, (alu_sel == 4'hF)}, 32'd1);
    check_all_regs();

    // LOADI, ADD with signed overflow into the sign bit
    issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h7F); wait_idle();
    issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01); wait_idle();
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00); wait_idle();
    check_reg(3'd3, 8'h80, "add_r3");
    chk("flags_add", {28'd0, flags}, 32'b0011);

    // SUB to zero, then SUB with borrow
    issue(OP_SUB, 3'd4, 3'd2, 3'd2, 8'h00); wait_idle();
    check_reg(3'd4, 8'h00, "sub_r4");
    chk("flags_sub_zero", {28'd0, flags}, 32'b1000);
    issue(OP_SUB, 3'd5, 3'd2, 3'd1, 8'h00); wait_idle();
    check_reg(3'd5, 8'h82, "sub_r5");
    chk("flags_sub_borrow", {28'd0, flags}, 32'b0110);

    // Rejected op code: one pulse, nothing written, flags kept
    ill_before = ill_cnt;
    issue(OP_BAD, 3'd1, 3'd2, 3'd3, 8'h55); wait_idle();
    chk("illegal_pulses", ill_cnt - ill_before, 32'd1);
    chk("flags_after_illegal", {28'd0, flags}, 32'b0110);
    check_all_regs();

    // Back-to-back with in_valid held: second reads the first's result
    issue(OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00);
    t1 = last_acc;
    issue(OP_XOR, 3'd7, 3'd6, 3'd1, 8'h00);
    chk("b2b_gap_cycles", 32'((last_acc - t1) / 10), 32'd3);
    wait_idle();
    check_reg(3'd7, 8'hFF, "b2b_r7");

    // Register 0 is an ordinary destination; logical shift right
    issue(OP_AND, 3'd0, 3'd1, 3'd5, 8'h00); wait_idle();
    check_reg(3'd0, 8'h02, "and_r0");
    issue(OP_SRL, 3'd3, 3'd3, 3'd2, 8'h00); wait_idle();
    check_reg(3'd3, 8'h40, "srl_r3");
    check_all_regs();

    // Reset while the ADD is in EXEC aborts it
    issue(OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00);
    @(negedge clk);
    in_valid  = 1'b0;
    reset     = 1'b1;
    wb_before = wb_cnt;
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_wb", wb_cnt, wb_before);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    check_reg(3'd6, 8'h00, "abort_r6");
    check_reg(3'd1, 8'h00, "abort_r1");

    // Arithmetic shift and signed compare
    issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h80); wait_idle();
    issue(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01); wait_idle();
    issue(OP_SRA, 3'd7, 3'd1, 3'd2, 8'h00); wait_idle();
    check_reg(3'd7, 8'hC0, "sra_r7");
    issue(OP_SLT, 3'd7, 3'd1, 3'd2, 8'h00); wait_idle();
    check_reg(3'd7, 8'h01, "slt_r7");
    check_all_regs();

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
